// File: rtl/qrd_pkg.sv
// Shared state type and default sizing for the delay/alignment buffer.
// Also holds the range check that decides whether a requested delay is accepted.
package qrd_pkg;

    localparam int DEFAULT_DATA_LENGTH = 8;
    localparam int DEFAULT_DEPTH       = 32;
    localparam int DEFAULT_P           = 22;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic delayInRange(input int delay, input int depth);
        return (delay >= 1) && (delay <= depth);
    endfunction

endpackage

// File: rtl/dpram_sync.sv
// Ring-buffer storage: one write port and one registered read port.
// When both ports hit the same address, the read returns the old contents.
module dpram_sync #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdData_q;

    // Non-blocking update gives read-before-write, which the full-depth delay relies on.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rdData_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/delay_align_buffer.sv
// Programmable delay line: every sample is written to a ring buffer and read back D cycles later.
// A FILL/RUN state machine masks the output until D samples of the current configuration exist.
module delay_align_buffer
    import qrd_pkg::*;
#(
    parameter  int DATA_LENGTH = DEFAULT_DATA_LENGTH,
    parameter  int DEPTH       = DEFAULT_DEPTH,
    parameter  int P           = DEFAULT_P,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_LENGTH-1:0] din,
    input  logic                   din_valid,
    input  logic                   cfg_load,
    input  logic [CW-1:0]          cfg_delay,
    output logic [DATA_LENGTH-1:0] dout,
    output logic                   dout_valid,
    output logic                   busy,
    output logic                   cfg_err
);

    state_e               state_q, state_d;
    logic [AW-1:0]        wp_q;
    logic [CW-1:0]        dly_q, dly_d;
    logic [CW-1:0]        fillCnt_q, fillCnt_d;
    logic                 cfgErr_q, cfgErr_d;
    logic                 cfgValid;
    logic [AW-1:0]        rdAddr;
    logic [DATA_LENGTH:0] rdData;

    assign cfgValid = delayInRange(int'(cfg_delay), DEPTH);
    assign rdAddr   = wp_q - dly_q[AW-1:0];

    dpram_sync #(
        .WIDTH (DATA_LENGTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (1'b1),
        .wr_addr_i (wp_q),
        .wr_data_i ({din_valid, din}),
        .rd_addr_i (rdAddr),
        .rd_data_o (rdData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            dly_q     <= CW'(P);
            fillCnt_q <= '0;
            wp_q      <= '0;
            cfgErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            fillCnt_q <= fillCnt_d;
            wp_q      <= wp_q + 1'b1;
            cfgErr_q  <= cfgErr_d;
        end
    end

    // fillCnt counts samples already captured for the current fill: reset drops the
    // reset-cycle sample, while a reconfiguration keeps the sample taken with cfg_load.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        fillCnt_d = fillCnt_q;
        cfgErr_d  = 1'b0;
        if (cfg_load && cfgValid) begin
            state_d   = FILL;
            dly_d     = cfg_delay;
            fillCnt_d = CW'(1);
        end else begin
            cfgErr_d = cfg_load;
            if (state_q == FILL) begin
                if (fillCnt_q == dly_q) begin
                    state_d = RUN;
                end else begin
                    fillCnt_d = fillCnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy       = (state_q == FILL);
        dout_valid = 1'b0;
        dout       = '0;
        if (state_q == RUN) begin
            dout_valid = rdData[DATA_LENGTH];
            dout       = rdData[DATA_LENGTH-1:0];
        end
    end

    assign cfg_err = cfgErr_q;

endmodule

// File: tb/tb_delay_align_buffer.sv
// Self-checking bench for delay_align_buffer: a sample-history model checked every cycle,
// plus directed literal expectations at the interesting points of each scenario.
module tb_delay_align_buffer;

    localparam int DL    = 8;
    localparam int DEPTH = 32;
    localparam int P     = 22;
    localparam int CW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [DL-1:0] din;
    logic          din_valid;
    logic          cfg_load;
    logic [CW-1:0] cfg_delay;
    logic [DL-1:0] dout;
    logic          dout_valid;
    logic          busy;
    logic          cfg_err;

    int total = 0;
    int bad   = 0;
    int rampVal = 0;

    always #5 clk = ~clk;

    delay_align_buffer #(
        .DATA_LENGTH (DL),
        .DEPTH       (DEPTH),
        .P           (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .cfg_load   (cfg_load),
        .cfg_delay  (cfg_delay),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [DL-1:0] d, input logic v,
                                 input logic ld, input logic [CW-1:0] dl);
        rst       = r;
        din       = d;
        din_valid = v;
        cfg_load  = ld;
        cfg_delay = dl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ramp(input int n);
        for (int i = 0; i < n; i++) begin
            rampVal++;
            applyStimulus(1'b0, rampVal[DL-1:0], 1'b1, 1'b0, '0);
        end
    endtask

    task automatic rampCfg(input logic r, input logic [CW-1:0] dl);
        rampVal++;
        applyStimulus(r, rampVal[DL-1:0], 1'b1, 1'b1, dl);
    endtask

    // Model: every captured sample is kept by edge index; output at edge e is the
    // sample from edge e-D once D samples of the current configuration exist.
    logic [DL:0]   hist [4096];
    int            edgeCnt = 0;
    int            modelD = P;
    int            firstSample = 0;
    logic          modelOn = 1'b0;
    logic          expErr, expBusy, expValid;
    logic [DL-1:0] expDout;

    always @(posedge clk) begin
        int e;
        e = edgeCnt;
        edgeCnt++;
        if (rst) begin
            modelD      = P;
            firstSample = e + 1;
            expErr      = 1'b0;
            modelOn     = 1'b1;
        end else if (cfg_load) begin
            if (cfg_delay >= 1 && cfg_delay <= DEPTH) begin
                modelD      = int'(cfg_delay);
                firstSample = e;
                expErr      = 1'b0;
            end else begin
                expErr = 1'b1;
            end
        end else begin
            expErr = 1'b0;
        end
        hist[e % 4096] = {din_valid, din};
        if ((e - firstSample) >= modelD) begin
            expBusy  = 1'b0;
            expValid = hist[(e - modelD) % 4096][DL];
            expDout  = hist[(e - modelD) % 4096][DL-1:0];
        end else begin
            expBusy  = 1'b1;
            expValid = 1'b0;
            expDout  = '0;
        end
        #1;
        if (modelOn) begin
            checkOutput("model dout", int'(dout), int'(expDout));
            checkOutput("model dout_valid", int'(dout_valid), int'(expValid));
            checkOutput("model busy", int'(busy), int'(expBusy));
            checkOutput("model cfg_err", int'(cfg_err), int'(expErr));
        end
    end

    initial begin
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rst = 1'b1; din = '0; din_valid = 1'b0; cfg_load = 1'b0; cfg_delay = '0;

        applyStimulus(1'b1, '0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, '0, 1'b0, 1'b0, '0);
        checkOutput("reset busy", int'(busy), 1);
        checkOutput("reset dout_valid", int'(dout_valid), 0);
        checkOutput("reset dout", int'(dout), 0);
        checkOutput("reset cfg_err", int'(cfg_err), 0);

        ramp(22);
        checkOutput("ramp still filling", int'(dout_valid), 0);
        checkOutput("ramp busy", int'(busy), 1);
        ramp(1);
        checkOutput("ramp first valid", int'(dout_valid), 1);
        checkOutput("ramp first dout", int'(dout), 1);
        checkOutput("ramp run busy", int'(busy), 0);
        ramp(17);
        checkOutput("ramp lag 22", int'(dout), 18);

        rampCfg(1'b0, 6'd5);
        checkOutput("cfg5 busy", int'(busy), 1);
        checkOutput("cfg5 masked", int'(dout_valid), 0);
        ramp(4);
        checkOutput("cfg5 busy end", int'(busy), 1);
        ramp(1);
        checkOutput("cfg5 run", int'(busy), 0);
        checkOutput("cfg5 first dout", int'(dout), 41);
        ramp(10);
        checkOutput("cfg5 lag", int'(dout), 51);

        rampCfg(1'b0, 6'd0);
        checkOutput("cfg0 err", int'(cfg_err), 1);
        checkOutput("cfg0 keeps run", int'(busy), 0);
        checkOutput("cfg0 keeps D", int'(dout), 52);
        ramp(1);
        checkOutput("cfg0 err pulse", int'(cfg_err), 0);
        rampCfg(1'b0, 6'd33);
        checkOutput("cfg33 err", int'(cfg_err), 1);
        checkOutput("cfg33 keeps D", int'(dout), 54);
        ramp(1);
        checkOutput("cfg33 err pulse", int'(cfg_err), 0);

        rampCfg(1'b0, 6'd3);
        ramp(5);
        for (int i = 0; i < 5; i++) begin
            rampVal++;
            applyStimulus(1'b0, rampVal[DL-1:0], pat[i], 1'b0, '0);
        end
        checkOutput("pattern slot1 valid", int'(dout_valid), 0);
        checkOutput("pattern slot1 dout", int'(dout), 68);
        ramp(1);
        checkOutput("pattern slot2 valid", int'(dout_valid), 1);
        ramp(1);
        checkOutput("pattern slot3 valid", int'(dout_valid), 1);
        ramp(1);
        checkOutput("pattern slot4 valid", int'(dout_valid), 0);

        rampCfg(1'b0, 6'd32);
        ramp(110);
        checkOutput("depth lag", int'(dout), 153);
        checkOutput("depth valid", int'(dout_valid), 1);

        rampCfg(1'b0, 6'd1);
        ramp(1);
        checkOutput("d1 run", int'(busy), 0);
        checkOutput("d1 first dout", int'(dout), 186);
        ramp(5);
        checkOutput("d1 lag", int'(dout), 191);

        rampCfg(1'b0, 6'd8);
        ramp(3);
        rampCfg(1'b0, 6'd4);
        ramp(3);
        checkOutput("refill busy", int'(busy), 1);
        ramp(1);
        checkOutput("refill run", int'(busy), 0);
        checkOutput("refill first dout", int'(dout), 197);
        ramp(10);
        checkOutput("refill lag", int'(dout), 207);

        rampCfg(1'b1, 6'd5);
        checkOutput("rst+cfg err", int'(cfg_err), 0);
        checkOutput("rst+cfg busy", int'(busy), 1);
        checkOutput("rst+cfg masked", int'(dout_valid), 0);
        ramp(22);
        checkOutput("rst+cfg still fill", int'(busy), 1);
        checkOutput("rst+cfg still masked", int'(dout_valid), 0);
        ramp(1);
        checkOutput("rst+cfg first valid", int'(dout_valid), 1);
        checkOutput("rst+cfg first dout", int'(dout), 213);

        rampCfg(1'b1, 6'd0);
        checkOutput("rst+badcfg err", int'(cfg_err), 0);
        ramp(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
